// File: rtl/mips_hz_pkg.sv
// Shared definitions for the MIPS pipeline hazard controller.
//   reg_idx_t       5-bit architectural register index
//   fwd_sel_e       forwarding mux select encoding (RF / E / M / W)
//   TUSE_NONE       tuse value meaning "operand not read"
//   MULT_CYC_DEF    default busy cycles for mult/multu
//   DIV_CYC_DEF     default busy cycles for div/divu
package mips_hz_pkg;

    typedef logic [4:0] reg_idx_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,  // register file or pipeline value
        FWD_E  = 2'd1,  // E stage (pc+8)
        FWD_M  = 2'd2,  // M stage
        FWD_W  = 2'd3   // W stage
    } fwd_sel_e;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

endpackage

// File: rtl/md_busy_tracker.sv
// Mult/div unit occupancy counter.
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high; clears the counter
//   md_start    in   mult/multu/div/divu in E; (re)loads the counter
//   md_div      in   1 = div/divu, 0 = mult/multu
//   md_busy     out  counter is non-zero
module md_busy_tracker
    import mips_hz_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start,
    input  logic md_div,
    output logic md_busy
);

    logic [3:0] count_q;

    // A start while still busy is illegal upstream; reloading keeps the
    // counter consistent with the most recent operation anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (md_start) begin
            count_q <= md_div ? 4'(DIV_CYC) : 4'(MULT_CYC);
        end else if (count_q != '0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign md_busy = (count_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core.
//   clk, reset               clock / synchronous active-high reset
//   rs_D, rt_D               D-stage source registers
//   tuse_rs_D, tuse_rt_D     cycles until D needs the operand (3 = unused)
//   md_use_D                 D instruction uses the mult/div unit
//   rs_E, rt_E, a3_E, tnew_E E-stage sources, destination, result latency
//   md_start_E, md_div_E     E holds a mult/div start, and which kind
//   rt_M, a3_M, tnew_M       M-stage store data source, destination, latency
//   a3_W                     W-stage destination
//   stall_D                  hold PC and IF/ID
//   clr_E                    bubble into ID/EX on the next edge
//   fwd_*                    forwarding mux selects (see fwd_sel_e)
//   md_busy                  mult/div unit occupied
//   stall_cnt                saturating count of stall cycles
module hazard_ctrl
    import mips_hz_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_D,
    input  logic [4:0]  rt_D,
    input  logic [1:0]  tuse_rs_D,
    input  logic [1:0]  tuse_rt_D,
    input  logic        md_use_D,
    input  logic [4:0]  rs_E,
    input  logic [4:0]  rt_E,
    input  logic [4:0]  a3_E,
    input  logic [1:0]  tnew_E,
    input  logic        md_start_E,
    input  logic        md_div_E,
    input  logic [4:0]  rt_M,
    input  logic [4:0]  a3_M,
    input  logic [1:0]  tnew_M,
    input  logic [4:0]  a3_W,
    output logic        stall_D,
    output logic        clr_E,
    output logic [1:0]  fwd_rs_D,
    output logic [1:0]  fwd_rt_D,
    output logic [1:0]  fwd_rs_E,
    output logic [1:0]  fwd_rt_E,
    output logic [1:0]  fwd_rt_M,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic [31:0] stall_cnt_q;

    function automatic logic hit(input reg_idx_t src, input reg_idx_t dst);
        return (src != '0) && (src == dst);
    endfunction

    function automatic logic raw_hz(input reg_idx_t src, input logic [1:0] tuse,
                                    input reg_idx_t dst, input logic [1:0] tnew);
        return hit(src, dst) && (tuse != TUSE_NONE) && (tnew > tuse);
    endfunction

    // The nearest matching producer wins even when it is not ready yet:
    // an older stage may hold a stale value of the same register.
    function automatic fwd_sel_e fwd_d(input reg_idx_t src,
                                       input reg_idx_t a3e, input logic [1:0] tne,
                                       input reg_idx_t a3m, input logic [1:0] tnm,
                                       input reg_idx_t a3w);
        if (hit(src, a3e)) return (tne == 2'd0) ? FWD_E : FWD_RF;
        if (hit(src, a3m)) return (tnm == 2'd0) ? FWD_M : FWD_RF;
        if (hit(src, a3w)) return FWD_W;
        return FWD_RF;
    endfunction

    function automatic fwd_sel_e fwd_e(input reg_idx_t src,
                                       input reg_idx_t a3m, input logic [1:0] tnm,
                                       input reg_idx_t a3w);
        if (hit(src, a3m)) return (tnm == 2'd0) ? FWD_M : FWD_RF;
        if (hit(src, a3w)) return FWD_W;
        return FWD_RF;
    endfunction

    md_busy_tracker #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start_E),
        .md_div   (md_div_E),
        .md_busy  (md_busy)
    );

    always_comb begin
        logic hz_rs, hz_rt, hz_md;

        stall_D  = 1'b0;
        fwd_rs_D = FWD_RF;
        fwd_rt_D = FWD_RF;
        fwd_rs_E = FWD_RF;
        fwd_rt_E = FWD_RF;
        fwd_rt_M = FWD_RF;

        hz_rs = raw_hz(rs_D, tuse_rs_D, a3_E, tnew_E) ||
                raw_hz(rs_D, tuse_rs_D, a3_M, tnew_M);
        hz_rt = raw_hz(rt_D, tuse_rt_D, a3_E, tnew_E) ||
                raw_hz(rt_D, tuse_rt_D, a3_M, tnew_M);
        hz_md = md_use_D && (md_busy || md_start_E);

        if (!reset) begin
            stall_D  = hz_rs || hz_rt || hz_md;
            fwd_rs_D = fwd_d(rs_D, a3_E, tnew_E, a3_M, tnew_M, a3_W);
            fwd_rt_D = fwd_d(rt_D, a3_E, tnew_E, a3_M, tnew_M, a3_W);
            fwd_rs_E = fwd_e(rs_E, a3_M, tnew_M, a3_W);
            fwd_rt_E = fwd_e(rt_E, a3_M, tnew_M, a3_W);
            fwd_rt_M = hit(rt_M, a3_W) ? FWD_W : FWD_RF;
        end

        clr_E = stall_D || reset;
    end

    // stall_D is already forced low during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (stall_D && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_D, rt_D, rs_E, rt_E, a3_E, rt_M, a3_M, a3_W;
    logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
    logic        md_use_D, md_start_E, md_div_E;
    logic        stall_D, clr_E, md_busy;
    logic [1:0]  fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_D       (rs_D),
        .rt_D       (rt_D),
        .tuse_rs_D  (tuse_rs_D),
        .tuse_rt_D  (tuse_rt_D),
        .md_use_D   (md_use_D),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .a3_E       (a3_E),
        .tnew_E     (tnew_E),
        .md_start_E (md_start_E),
        .md_div_E   (md_div_E),
        .rt_M       (rt_M),
        .a3_M       (a3_M),
        .tnew_M     (tnew_M),
        .a3_W       (a3_W),
        .stall_D    (stall_D),
        .clr_E      (clr_E),
        .fwd_rs_D   (fwd_rs_D),
        .fwd_rt_D   (fwd_rt_D),
        .fwd_rs_E   (fwd_rs_E),
        .fwd_rt_E   (fwd_rt_E),
        .fwd_rt_M   (fwd_rt_M),
        .md_busy    (md_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef enum int {K_STALL, K_CLR, K_FRSD, K_FRTD, K_FRSE, K_FRTE, K_FRTM,
                      K_BUSY, K_CNT} kind_e;
    typedef struct {
        string       name;
        kind_e       kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_cnt  = '0;

    function automatic logic [31:0] observe(input kind_e k);
        case (k)
            K_STALL: return {31'd0, stall_D};
            K_CLR:   return {31'd0, clr_E};
            K_FRSD:  return {30'd0, fwd_rs_D};
            K_FRTD:  return {30'd0, fwd_rt_D};
            K_FRSE:  return {30'd0, fwd_rs_E};
            K_FRTE:  return {30'd0, fwd_rt_E};
            K_FRTM:  return {30'd0, fwd_rt_M};
            K_BUSY:  return {31'd0, md_busy};
            default: return stall_cnt;
        endcase
    endfunction

    task automatic push(input string n, input kind_e k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic clear_inputs();
        rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3; md_use_D = 1'b0;
        rs_E = '0; rt_E = '0; a3_E = '0; tnew_E = '0; md_start_E = 1'b0; md_div_E = 1'b0;
        rt_M = '0; a3_M = '0; tnew_M = '0; a3_W = '0;
    endtask

    task automatic test_reset();
        exp_t e;
        logic [31:0] obs;
        reset = 1'b1;
        clear_inputs();
        rs_D = 5'd1; rt_D = 5'd1; tuse_rs_D = 2'd0; tuse_rt_D = 2'd0; md_use_D = 1'b1;
        rs_E = 5'd1; rt_E = 5'd1; rt_M = 5'd1; a3_E = 5'd1; tnew_E = 2'd2;
        a3_M = 5'd1; a3_W = 5'd1; md_start_E = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            if (c == 2) begin
                reset = 1'b0;
                clear_inputs();
            end
            push("rst_stall", K_STALL, 32'd0);
            push("rst_clr",   K_CLR,   (c < 2) ? 32'd1 : 32'd0);
            push("rst_frsd",  K_FRSD,  32'd0);
            push("rst_frtd",  K_FRTD,  32'd0);
            push("rst_frse",  K_FRSE,  32'd0);
            push("rst_frte",  K_FRTE,  32'd0);
            push("rst_frtm",  K_FRTM,  32'd0);
            push("rst_busy",  K_BUSY,  32'd0);
            push("rst_cnt",   K_CNT,   32'd0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %0h, expected %0h", e.name, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // lw $1 walks E -> M -> W while a branch in D reads $1 at tuse 0,
    // then an rt-side hazard against E.
    task automatic test_load_use();
        exp_t e;
        logic [31:0] obs;
        for (int unsigned c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: begin rs_D = 5'd1; tuse_rs_D = 2'd0; a3_E = 5'd1; tnew_E = 2'd2; end
                1: begin rs_D = 5'd1; tuse_rs_D = 2'd0; a3_M = 5'd1; tnew_M = 2'd1; end
                2: begin rs_D = 5'd1; tuse_rs_D = 2'd0; a3_W = 5'd1; end
                3: begin rt_D = 5'd1; tuse_rt_D = 2'd1; a3_E = 5'd1; tnew_E = 2'd2; end
                default: ;
            endcase
            push("lu_stall", K_STALL, (c == 2 || c == 4) ? 32'd0 : 32'd1);
            push("lu_clr",   K_CLR,   (c == 2 || c == 4) ? 32'd0 : 32'd1);
            push("lu_frsd",  K_FRSD,  (c == 2) ? 32'd3 : 32'd0);
            push("lu_frtd",  K_FRTD,  32'd0);
            push("lu_cnt",   K_CNT,   exp_cnt);
            if (c != 2 && c != 4) exp_cnt++;
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h, expected %0h", e.name, c, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // jal in E, then M/W forwarding into D and the $0 boundary.
    task automatic test_d_forward();
        exp_t e;
        logic [31:0] obs;
        for (int unsigned c = 0; c < 5; c++) begin
            clear_inputs();
            case (c)
                0: begin rs_D = 5'd31; tuse_rs_D = 2'd0; a3_E = 5'd31; tnew_E = 2'd0; end
                1: begin rs_D = 5'd31; tuse_rs_D = 2'd0; a3_E = 5'd0;  tnew_E = 2'd0; end
                2: begin rs_D = 5'd7; tuse_rs_D = 2'd0; a3_M = 5'd7; tnew_M = 2'd0;
                         rt_D = 5'd9; tuse_rt_D = 2'd1; a3_W = 5'd9; end
                3: begin rs_D = 5'd0; tuse_rs_D = 2'd0; a3_E = 5'd0; tnew_E = 2'd2; end
                default: begin rt_D = 5'd4; tuse_rt_D = 2'd3; a3_E = 5'd4; tnew_E = 2'd2; end
            endcase
            push("df_stall", K_STALL, 32'd0);
            push("df_frsd",  K_FRSD,  (c == 0) ? 32'd1 : (c == 2) ? 32'd2 : 32'd0);
            push("df_frtd",  K_FRTD,  (c == 2) ? 32'd3 : 32'd0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h, expected %0h", e.name, c, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // mult (6 stall cycles) then div (11 stall cycles) ahead of an mflo in D.
    task automatic test_md_stall(input logic is_div);
        exp_t e;
        logic [31:0] obs;
        int unsigned n_stall;
        n_stall = is_div ? 11 : 6;
        for (int unsigned c = 0; c < n_stall + 2; c++) begin
            clear_inputs();
            md_use_D = 1'b1;
            if (c == 0) begin
                md_start_E = 1'b1;
                md_div_E   = is_div;
            end
            push(is_div ? "div_stall" : "mul_stall", K_STALL, (c < n_stall) ? 32'd1 : 32'd0);
            push(is_div ? "div_busy" : "mul_busy", K_BUSY,
                 (c >= 1 && c < n_stall) ? 32'd1 : 32'd0);
            push(is_div ? "div_cnt" : "mul_cnt", K_CNT, exp_cnt);
            if (c < n_stall) exp_cnt++;
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h, expected %0h", e.name, c, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_e_forward();
        exp_t e;
        logic [31:0] obs;
        for (int unsigned c = 0; c < 4; c++) begin
            clear_inputs();
            a3_E = 5'd5; a3_M = 5'd5; a3_W = 5'd5; rs_E = 5'd5; rt_E = 5'd5;
            rs_D = 5'd6; tuse_rs_D = 2'd0;
            case (c)
                0: tnew_M = 2'd0;
                1: begin tnew_M = 2'd1; tnew_E = 2'd2; end
                2: begin a3_M = 5'd0; rt_M = 5'd5; end
                default: begin a3_M = 5'd0; rt_M = 5'd0; rs_E = 5'd0; end
            endcase
            push("ef_stall", K_STALL, 32'd0);
            push("ef_frse",  K_FRSE,  (c == 0) ? 32'd2 : (c == 2) ? 32'd3 : 32'd0);
            push("ef_frte",  K_FRTE,  (c == 0) ? 32'd2 : (c == 1) ? 32'd0 : 32'd3);
            push("ef_frtm",  K_FRTM,  (c == 2) ? 32'd3 : 32'd0);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h, expected %0h", e.name, c, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    // div loads 10; reset lands while the count is 7.
    task automatic test_reset_mid_div();
        exp_t e;
        logic [31:0] obs;
        for (int unsigned c = 0; c < 7; c++) begin
            clear_inputs();
            reset = (c == 4 || c == 5);
            if (c == 0) begin
                md_start_E = 1'b1;
                md_div_E   = 1'b1;
            end
            if (c == 5) exp_cnt = '0;
            push("rd_busy",  K_BUSY,  (c >= 1 && c <= 4) ? 32'd1 : 32'd0);
            push("rd_clr",   K_CLR,   reset ? 32'd1 : 32'd0);
            push("rd_stall", K_STALL, 32'd0);
            push("rd_cnt",   K_CNT,   exp_cnt);
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h, expected %0h", e.name, c, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_saturate();
        exp_t e;
        logic [31:0] obs;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        exp_cnt = 32'hFFFF_FFFE;
        for (int unsigned c = 0; c < 4; c++) begin
            clear_inputs();
            if (c < 3) begin
                rs_D = 5'd3; tuse_rs_D = 2'd0; a3_E = 5'd3; tnew_E = 2'd1;
            end
            push("sat_stall", K_STALL, (c < 3) ? 32'd1 : 32'd0);
            push("sat_cnt",   K_CNT,   exp_cnt);
            if (c < 3 && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
            @(negedge clk);
            while (sb.size() > 0) begin
                e = sb.pop_front(); obs = observe(e.kind); n_checks++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s[%0d]: got %0h, expected %0h", e.name, c, obs, e.val);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_d_forward();
        test_md_stall(1'b0);
        test_md_stall(1'b1);
        test_e_forward();
        test_reset_mid_div();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
